// File: rtl/clock_ctrl.sv
// clock_ctrl: sequencing controller for the cascaded seconds/minutes/hours
// counters of a digital clock.
//
// RUN mode turns each tick_1hz into the carry chain (inc/clr pulses to the
// three stages). SET modes freeze time and let the user bump one field with
// btn_inc; btn_mode walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN. With
// no button activity for TIMEOUT_S ticks in a SET mode the block drops back
// to RUN.
//
// Ports:
//   clk, clrn             clock, async active-low reset
//   tick_1hz              1-cycle pulse once per second
//   btn_mode, btn_inc     debounced synchronous button levels
//   sec_top/min_top/hour_top  stage at terminal value (59/59/23)
//   sec_/min_/hour_inc    registered 1-cycle increment pulses
//   sec_/min_/hour_clr    registered 1-cycle clear pulses
//   mode                  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//   blink                 blink enable for the field being set
module clock_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_top,
  input  logic       min_top,
  input  logic       hour_top,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       sec_clr,
  output logic       min_clr,
  output logic       hour_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
  localparam logic [1:0] SET_SEC  = 2'd3;

  // Counter value at which the next tick expires the idle window.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_S - 1);
  localparam bit         TO_EN   = (TIMEOUT_S != 0);

  logic [1:0] state_q, state_d;
  logic       btn_mode_q, btn_inc_q;
  logic [7:0] idle_q, idle_d;
  logic       blink_d;
  logic       mode_evt, inc_evt, in_set, timeout, state_chg;
  // {hour, min, sec}
  logic [2:0] inc_d, clr_d;

  assign mode_evt  = btn_mode & ~btn_mode_q;
  assign inc_evt   = btn_inc  & ~btn_inc_q;
  assign in_set    = (state_q != RUN);
  // A button edge on the expiring tick keeps the user in SET.
  assign timeout   = TO_EN & in_set & tick_1hz & (idle_q == TO_LAST) &
                     ~mode_evt & ~inc_evt;

  always_comb begin
    state_d = state_q;
    if (mode_evt)     state_d = state_q + 2'd1;  // SET_SEC wraps to RUN
    else if (timeout) state_d = RUN;
  end

  assign state_chg = (state_d != state_q);

  // Pulse decode. In SET modes mode_evt takes priority over inc_evt.
  always_comb begin
    inc_d = 3'b000;
    clr_d = 3'b000;
    case (state_q)
      RUN: if (tick_1hz) begin
        if (!sec_top) inc_d[0] = 1'b1;
        else begin
          clr_d[0] = 1'b1;
          if (!min_top) inc_d[1] = 1'b1;
          else begin
            clr_d[1] = 1'b1;
            if (hour_top) clr_d[2] = 1'b1;
            else          inc_d[2] = 1'b1;
          end
        end
      end
      SET_HOUR: if (inc_evt && !mode_evt) begin
        if (hour_top) clr_d[2] = 1'b1;
        else          inc_d[2] = 1'b1;
      end
      SET_MIN: if (inc_evt && !mode_evt) begin
        if (min_top) clr_d[1] = 1'b1;
        else         inc_d[1] = 1'b1;
      end
      default: if (inc_evt && !mode_evt) clr_d[0] = 1'b1;  // SET_SEC: zero seconds
    endcase
  end

  always_comb begin
    idle_d = idle_q;
    if (state_chg || mode_evt || inc_evt)             idle_d = 8'd0;
    else if (in_set && tick_1hz && idle_q != 8'hFF)   idle_d = idle_q + 8'd1;
  end

  always_comb begin
    blink_d = blink;
    if (state_chg || !in_set) blink_d = 1'b0;
    else if (tick_1hz)        blink_d = ~blink;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= RUN;
      btn_mode_q <= 1'b1;  // button held through reset gives no edge
      btn_inc_q  <= 1'b1;
      idle_q     <= 8'd0;
      blink      <= 1'b0;
      sec_inc    <= 1'b0;
      min_inc    <= 1'b0;
      hour_inc   <= 1'b0;
      sec_clr    <= 1'b0;
      min_clr    <= 1'b0;
      hour_clr   <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      idle_q     <= idle_d;
      blink      <= blink_d;
      sec_inc    <= inc_d[0];
      min_inc    <= inc_d[1];
      hour_inc   <= inc_d[2];
      sec_clr    <= clr_d[0];
      min_clr    <= clr_d[1];
      hour_clr   <= clr_d[2];
    end
  end

  assign mode = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
module tb_clock_ctrl;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic sec_top = 1'b0, min_top = 1'b0, hour_top = 1'b0;
  logic sec_inc, min_inc, hour_inc, sec_clr, min_clr, hour_clr, blink;
  logic [1:0] mode;
  logic [5:0] outs;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clock_ctrl #(.TIMEOUT_S(10)) dut (
    .clk(clk), .clrn(clrn), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .sec_top(sec_top), .min_top(min_top), .hour_top(hour_top),
    .sec_inc(sec_inc), .min_inc(min_inc), .hour_inc(hour_inc),
    .sec_clr(sec_clr), .min_clr(min_clr), .hour_clr(hour_clr),
    .mode(mode), .blink(blink)
  );

  // {sec_inc, sec_clr, min_inc, min_clr, hour_inc, hour_clr}
  assign outs = {sec_inc, sec_clr, min_inc, min_clr, hour_inc, hour_clr};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
  endtask

  task automatic test_reset();
    btn_mode = 1'b1;
    #1;
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode: got %0d want 0", mode); end
    vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL reset_outs: got %b want 000000", outs); end
    vectors++; if (blink !== 1'b0) begin miscompares++; $display("FAIL reset_blink: got %b want 0", blink); end
    step(); step();
    clrn = 1'b1;
    step(); step(); step();
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL held_btn_no_edge: got %0d want 0", mode); end
    btn_mode = 1'b0; step();
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL release_no_edge: got %0d want 0", mode); end
    btn_mode = 1'b1; step();
    vectors++; if (mode !== 2'd1) begin miscompares++; $display("FAIL press_to_set_hour: got %0d want 1", mode); end
    btn_mode = 1'b0; step();
    press_mode(); press_mode(); press_mode();
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL mode_wrap_run: got %0d want 0", mode); end
  endtask

  task automatic test_carry();
    sec_top = 1'b1; min_top = 1'b1; hour_top = 1'b0; tick_1hz = 1'b1; step();
    vectors++; if (outs !== 6'b010110) begin miscompares++; $display("FAIL carry_hour_inc: got %b want 010110", outs); end
    tick_1hz = 1'b0; step();
    vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL carry_pulse_width: got %b want 000000", outs); end
    hour_top = 1'b1; tick_1hz = 1'b1; step();
    vectors++; if (outs !== 6'b010101) begin miscompares++; $display("FAIL carry_midnight: got %b want 010101", outs); end
    min_top = 1'b0; hour_top = 1'b0; tick_1hz = 1'b1; step();
    vectors++; if (outs !== 6'b011000) begin miscompares++; $display("FAIL carry_min_inc: got %b want 011000", outs); end
    tick_1hz = 1'b0; sec_top = 1'b0; step();
    vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL carry_idle: got %b want 000000", outs); end
  endtask

  task automatic test_sec_run();
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1; step();
      vectors++; if (outs !== 6'b100000) begin miscompares++; $display("FAIL run_sec_inc_%0d: got %b want 100000", i, outs); end
      tick_1hz = 1'b0; step();
      vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL run_sec_gap_%0d: got %b want 000000", i, outs); end
    end
    btn_inc = 1'b1; step();
    vectors++; if (outs !== 6'b0 || mode !== 2'd0) begin miscompares++; $display("FAIL run_ignores_inc: got outs=%b mode=%0d want 000000/0", outs, mode); end
    btn_inc = 1'b0; step();
  endtask

  task automatic test_set_min_sec();
    press_mode(); press_mode();
    vectors++; if (mode !== 2'd2 || blink !== 1'b0) begin miscompares++; $display("FAIL enter_set_min: got mode=%0d blink=%b want 2/0", mode, blink); end
    min_top = 1'b1; btn_inc = 1'b1; step();
    vectors++; if (outs !== 6'b000100) begin miscompares++; $display("FAIL set_min_clr: got %b want 000100", outs); end
    btn_inc = 1'b0; min_top = 1'b0; step();
    vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL set_min_clr_width: got %b want 000000", outs); end
    tick_1hz = 1'b1; sec_top = 1'b1; step();
    vectors++; if (outs !== 6'b0 || blink !== 1'b1) begin miscompares++; $display("FAIL set_min_tick: got outs=%b blink=%b want 000000/1", outs, blink); end
    tick_1hz = 1'b0; sec_top = 1'b0; step();
    btn_inc = 1'b1; step();
    vectors++; if (outs !== 6'b001000) begin miscompares++; $display("FAIL set_min_inc: got %b want 001000", outs); end
    btn_inc = 1'b0; step();
    press_mode();
    vectors++; if (mode !== 2'd3 || blink !== 1'b0) begin miscompares++; $display("FAIL enter_set_sec: got mode=%0d blink=%b want 3/0", mode, blink); end
    btn_inc = 1'b1; step();
    vectors++; if (outs !== 6'b010000) begin miscompares++; $display("FAIL set_sec_clr: got %b want 010000", outs); end
    btn_inc = 1'b0; step();
    btn_mode = 1'b1; btn_inc = 1'b1; step();
    vectors++; if (mode !== 2'd0 || outs !== 6'b0) begin miscompares++; $display("FAIL mode_beats_inc: got mode=%0d outs=%b want 0/000000", mode, outs); end
    btn_mode = 1'b0; btn_inc = 1'b0; step();
    vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL mode_beats_inc_after: got %b want 000000", outs); end
  endtask

  task automatic test_timeout();
    press_mode();
    for (int i = 1; i <= 10; i++) begin
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0;
      if (i == 9) begin
        vectors++; if (mode !== 2'd1 || blink !== 1'b1) begin miscompares++; $display("FAIL timeout_tick9: got mode=%0d blink=%b want 1/1", mode, blink); end
      end
      step();
    end
    vectors++; if (mode !== 2'd0 || blink !== 1'b0) begin miscompares++; $display("FAIL timeout_expire: got mode=%0d blink=%b want 0/0", mode, blink); end
    press_mode();
    for (int i = 1; i <= 10; i++) begin
      tick_1hz = 1'b1;
      if (i == 9) btn_inc = 1'b1;
      step();
      if (i == 9) begin
        vectors++; if (outs !== 6'b000010) begin miscompares++; $display("FAIL set_hour_inc_on_tick: got %b want 000010", outs); end
      end
      tick_1hz = 1'b0; btn_inc = 1'b0; step();
    end
    vectors++; if (mode !== 2'd1) begin miscompares++; $display("FAIL timeout_rearmed: got %0d want 1", mode); end
    hour_top = 1'b1; btn_inc = 1'b1; step();
    vectors++; if (outs !== 6'b000001) begin miscompares++; $display("FAIL set_hour_clr: got %b want 000001", outs); end
    btn_inc = 1'b0; hour_top = 1'b0; step();
    press_mode(); press_mode(); press_mode();
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL back_to_run: got %0d want 0", mode); end
  endtask

  task automatic test_tick_and_mode();
    tick_1hz = 1'b1; btn_mode = 1'b1; step();
    vectors++; if (outs !== 6'b100000 || mode !== 2'd1) begin miscompares++; $display("FAIL tick_with_mode: got outs=%b mode=%0d want 100000/1", outs, mode); end
    tick_1hz = 1'b0; btn_mode = 1'b0; step();
    press_mode(); press_mode(); press_mode();
  endtask

  task automatic test_reset_mid_pulse();
    tick_1hz = 1'b1; step();
    vectors++; if (outs !== 6'b100000) begin miscompares++; $display("FAIL pre_reset_pulse: got %b want 100000", outs); end
    tick_1hz = 1'b0;
    clrn = 1'b0; #1;
    vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL async_reset_drop: got %b want 000000", outs); end
    step(); clrn = 1'b1; step();
    vectors++; if (outs !== 6'b0 || mode !== 2'd0) begin miscompares++; $display("FAIL no_reissue: got outs=%b mode=%0d want 000000/0", outs, mode); end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_sec_run();
    test_set_min_sec();
    test_timeout();
    test_tick_and_mode();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Sequencing controller for the three cascaded time counters (seconds, minutes, hours) of the digital clock.
- Issues one-cycle increment and clear pulses to each stage.
- In RUN mode it performs carry propagation from the 1 Hz tick.
- In SET modes it halts timekeeping and lets the user adjust one selected field with mode/increment buttons, returning to RUN automatically after an idle timeout.

Parameters:
- TIMEOUT_S, 10: number of consecutive tick_1hz pulses with no button edge, while in a SET mode, before the block returns to RUN. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  system clock; all counters share this clock.
- clrn  input  1  reset, asynchronous, active-low.
- tick_1hz  input  1  one-clk-cycle pulse, once per second, synchronous to clk.
- btn_mode  input  1  debounced, synchronous mode button level.
- btn_inc  input  1  debounced, synchronous increment button level.
- sec_top  input  1  seconds stage at terminal value (59).
- min_top  input  1  minutes stage at terminal value (59).
- hour_top  input  1  hours stage at terminal value (23).
- sec_inc, min_inc, hour_inc  output  1 each  increment pulse to the stage.
- sec_clr, min_clr, hour_clr  output  1 each  synchronous clear pulse to the stage.
- mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- blink  output  1  display blink enable for the selected field.

Behaviour:
- Reset (clrn=0, async):
  - state=RUN; all inc/clr outputs=0; blink=0; timeout counter=0.
  - Button history registers are set to 1, so a button held through reset produces no edge until it is released and pressed again.
- Edge detect: mode_evt = btn_mode & ~btn_mode_q; inc_evt = btn_inc & ~btn_inc_q; history registers update every cycle.
- Output timing:
  - All inc/clr outputs are registered, high for exactly 1 cycle.
  - They are asserted in the cycle after the cycle in which the triggering event (tick or edge) and the *_top inputs are sampled.
  - Within a stage, inc and clr are never both 1.
- State transitions on mode_evt: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN. The mode output changes 1 cycle after mode_evt.
- RUN, on tick_1hz:
  - sec_top=0: sec_inc.
  - sec_top=1: sec_clr. In addition:
    - min_top=0: min_inc.
    - min_top=1: min_clr, and hour_top ? hour_clr : hour_inc.
  - inc_evt is ignored in RUN.
- SET_HOUR, on inc_evt: hour_top ? hour_clr : hour_inc. No carry.
- SET_MIN, on inc_evt: min_top ? min_clr : min_inc. No carry into hours.
- SET_SEC, on inc_evt: sec_clr, regardless of sec_top.
- SET modes and tick_1hz:
  - tick_1hz produces no counting; time is frozen.
  - blink toggles on each tick_1hz.
  - blink is forced to 0 in RUN and on every state change.
- Timeout:
  - An 8-bit idle counter clears on entry to any SET state and on any mode_evt/inc_evt.
  - In a SET state it increments on each tick_1hz.
  - When a tick arrives with the counter at TIMEOUT_S-1 (and TIMEOUT_S≠0), the next state is RUN. No inc/clr pulse is issued for that tick.
- Simultaneous events:
  - mode_evt and inc_evt in the same cycle: mode_evt wins, inc_evt is discarded.
  - tick_1hz and mode_evt in the same cycle in RUN: the tick carry is executed, and the state still advances to SET_HOUR.
  - Timeout tick and inc_evt in the same cycle: inc_evt is executed and the counter clears, so no timeout occurs.
- Reset mid-pulse: outputs drop immediately (async). No pulse is reissued after reset.

Test Plan:
- Reset with btn_mode held at 1, release, press -> no transition before release; after the press, mode goes 0->1 exactly one cycle later.
- RUN, tick with sec_top=1, min_top=1, hour_top=0 -> one-cycle pulse with sec_clr=1, min_clr=1, hour_inc=1, all other outputs 0.
- RUN, 3 ticks with all top=0 -> exactly 3 sec_inc pulses, each 1 cycle wide; min/hour outputs stay 0.
- SET_MIN, inc_evt with min_top=1 -> min_clr only, no hour_inc; tick in SET_MIN -> no inc/clr pulse, blink toggles 0->1.
- SET_HOUR with TIMEOUT_S=10, 10 ticks and no buttons -> mode returns to 0 after the 10th tick and blink=0; repeat with an inc_evt at tick 9 -> still mode=1 after 10 ticks.
- mode_evt and inc_evt in the same cycle in SET_SEC -> mode=0, no sec_clr pulse.
